ls169_cascade: RTL
==================

Name: ls169_cascade

Overview:
- Synchronous presettable up/down binary counter built from N cascaded MB74LS169-style 4-bit stages.
- Companion to the up-only 4-bit counter already in the logic library. Adds the count-down direction needed by the video/sprite timing chains, which preload a value and count to zero.
- Stages are chained internally through their active-low ripple-carry outputs. Externally the block behaves as one 4*N_STAGES-bit counter with a single terminal-count output.

Parameters:
- N_STAGES, 2, number of 4-bit stages; counter width W = 4*N_STAGES; legal range 1..8.

Ports:
- _CLK, input, 1, clock; all state changes on the rising edge.
- _RST, input, 1, asynchronous reset, active-high.
- _LOAD, input, 1, synchronous parallel load, active-low.
- _ENP, input, 1, count enable P, active-low; broadcast to every stage.
- _ENT, input, 1, count enable T, active-low; feeds stage 0 only.
- _UD, input, 1, direction: 1 = up, 0 = down.
- _D, input, W, parallel load data; bit 0 is the LSB.
- _Q, output, W, counter value; registered.
- _RCO, output, 1, ripple carry out of the last stage, active-low; combinational.

Behaviour:
- Reset:
  - _RST high forces _Q = 0 immediately, independent of _CLK.
  - _RST overrides load and count. Deassertion takes effect at the next rising edge.
  - Reset mid-count or mid-load discards the operation in progress.
- Priority at each rising _CLK edge, with _RST low:
  - First, if _LOAD = 0, then _Q <= _D. Enables and _UD are ignored.
  - Otherwise, if _ENP = 0 and _ENT = 0: _Q <= _Q + 1 when _UD = 1, or _Q <= _Q - 1 when _UD = 0.
  - Otherwise, _Q holds.
- Arithmetic: modulo 2^W.
  - Up from all-ones wraps to 0.
  - Down from 0 wraps to all-ones.
  - No saturation.
- Cascade structure:
  - Stage k (k > 0) receives _ENT_k = _RCO of stage k-1, and _ENP_k = _ENP.
  - Stage 0 receives the external _ENT.
  - Stage k is therefore active only when every lower stage sits at its terminal value for the current direction.
  - Net effect must equal a single W-bit up/down counter. The internal per-stage carries are only the implementation structure.
- Per-stage RCO (active-low): low iff the stage's _ENT is 0 and its nibble is at terminal count, i.e. 4'hF with _UD = 1, or 4'h0 with _UD = 0.
- External _RCO:
  - Equals the last stage's RCO.
  - Low iff _ENT = 0 and _Q is all-ones (up) or all-zeros (down).
  - Independent of _ENP, per the datasheet.
  - Combinational from _Q, _UD and _ENT, so it responds within the same cycle when _UD or _ENT change.
- _UD is sampled only at the rising edge for counting. A direction change between edges is legal and takes effect on the next edge; _RCO follows immediately.
- Latency:
  - Load and count: 1 clock (_Q updates at the edge).
  - Reset: asynchronous, zero clocks.
- No glitch requirement on _RCO beyond combinational settling within one cycle.

Optional Feature:
- Macro: LS169_CASCADE_STAGE_RCO_EN.
- Defined:
  - Adds output port _RCO_STG, N_STAGES bits wide. Bit k is the active-low RCO of stage k, as defined above.
  - Used by the timing chain to tap the intermediate divide-by-16^k terminal counts.
- Undefined:
  - Port absent; per-stage carries stay internal.
  - All other behaviour is identical in both builds.

Test Plan:
- Reset: assert _RST mid-count with _Q = 8'h5A -> _Q = 8'h00 with no clock edge. Hold _RST high over 3 edges with _LOAD = 0 and _D = 8'hFF -> _Q stays 8'h00.
- Load priority: _LOAD = 0, _ENP = 0, _ENT = 0, _UD = 1, _D = 8'h3C -> after 1 edge _Q = 8'h3C, not 8'h3D. A second edge with _LOAD = 1 -> _Q = 8'h3D.
- Down count across nibble boundary and wrap: load 8'h10, _UD = 0, enables low.
  - After 1 edge: _Q = 8'h0F.
  - Load 8'h01, then 1 edge: _Q = 8'h00 and _RCO = 0.
  - Next edge: _Q = 8'hFF and _RCO = 1.
- Up carry and enables:
  - Load 8'hFE, _UD = 1: next edge _Q = 8'hFF, _RCO = 0.
  - Set _ENP = 1: _Q holds at 8'hFF and _RCO stays 0.
  - Set _ENT = 1: _RCO = 1 and _Q holds.
- Direction flip: _Q = 8'h00, _UD = 0, _ENT = 0 -> _RCO = 0. Switch _UD to 1 between edges -> _RCO = 1 before the next edge, and the next enabled edge gives _Q = 8'h01.
- With LS169_CASCADE_STAGE_RCO_EN defined, _UD = 1, _ENT = 0, _Q = 8'h2F -> _RCO_STG = 2'b10 and _RCO = 1. Next edge: _Q = 8'h30 and _RCO_STG = 2'b11.

Source files
------------

// File: rtl/ls169_cascade.sv
// ls169_cascade: N cascaded 4-bit synchronous presettable up/down counters.
// Define LS169_CASCADE_STAGE_RCO_EN to expose the per-stage ripple carries.
module ls169_cascade #(
    parameter int N_STAGES = 2
) (
    input  logic                  _CLK,
    input  logic                  _RST,
    input  logic                  _LOAD,
    input  logic                  _ENP,
    input  logic                  _ENT,
    input  logic                  _UD,
    input  logic [4*N_STAGES-1:0] _D,
    output logic [4*N_STAGES-1:0] _Q,
`ifdef LS169_CASCADE_STAGE_RCO_EN
    output logic [N_STAGES-1:0]   _RCO_STG,
`endif
    output logic                  _RCO
);

    logic [N_STAGES-1:0] term;
    logic [N_STAGES-1:0] ent_n;
    logic [N_STAGES-1:0] rco_n;
    logic                run;

    // Per-stage terminal detect: all ones when counting up, all zeros down.
    always_comb begin
        term = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            term[k] = (_Q[4*k +: 4] == {4{_UD}});
        end
    end

    // Carry chain, flattened: stage k's ENT is the RCO of stage k-1, which is
    // low only while the external ENT is low and every lower nibble is terminal.
    always_comb begin
        run   = ~_ENT;
        ent_n = '1;
        rco_n = '1;
        for (int k = 0; k < N_STAGES; k++) begin
            ent_n[k] = ~run;
            rco_n[k] = ~(run & term[k]);
            run      = run & term[k];
        end
    end

    assign _RCO = rco_n[N_STAGES-1];

`ifdef LS169_CASCADE_STAGE_RCO_EN
    assign _RCO_STG = rco_n;
`endif

    // Counter state: async reset, then load, then per-stage enabled count.
    always_ff @(posedge _CLK or posedge _RST) begin
        if (_RST) begin
            _Q <= '0;
        end else if (!_LOAD) begin
            _Q <= _D;
        end else if (!_ENP) begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (!ent_n[k]) begin
                    if (_UD) _Q[4*k +: 4] <= _Q[4*k +: 4] + 4'd1;
                    else     _Q[4*k +: 4] <= _Q[4*k +: 4] - 4'd1;
                end
            end
        end
    end

endmodule
